buf_scanout: RTL and testbench
==============================

Name: buf_scanout

Overview:
Frame-buffer reader for the display adapter. Generates raster timing (h/v counters, hsync, vsync, data-enable) and issues read-enable and address to a single frame buffer (registered read, 1-cycle latency, 24-bit RGB out). Re-times the returned RGB so pixel data, sync and DE leave the block aligned. Sits between the frame buffer and the display output pins.

Parameters:
H_ACTIVE, 100, visible pixels per line
V_ACTIVE, 100, visible lines per frame
H_FP, 4, horizontal front porch (clocks)
H_SYNC, 8, hsync width (clocks)
H_BP, 4, horizontal back porch (clocks)
V_FP, 1, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 1, vertical back porch (lines)
ADDR_W, 20, buffer address width

Ports:
clk  in  1  pixel clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  scan enable; level-sensitive
RE  out  1  buffer read enable
Addr  out  ADDR_W  buffer read address
R_in / G_in / B_in  in  8 each  buffer read data, valid cycle after RE
R_out / G_out / B_out  out  8 each  pixel data, 0 when de=0
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
de  out  1  active-video data enable
frame_start  out  1  one-cycle pulse on first clock of each frame

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0, Addr=0, RE=0, de=0, hsync=1, vsync=1, RGB_out=0, frame_start=0.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP. hcnt wraps H_TOTAL-1->0 and advances vcnt; vcnt wraps V_TOTAL-1->0.
- States: IDLE (counters held at 0, RE=0, syncs inactive); RUN (counting); DRAIN (counting, en low, finish current frame).
- IDLE->RUN when en=1; first RUN cycle is hcnt=0,vcnt=0, frame_start=1.
- RUN->DRAIN when en=0 mid-frame; DRAIN->IDLE on wrap to (0,0) with en=0. DRAIN->RUN if en returns before wrap. RUN at (0,0) wrap with en=0 -> IDLE directly. Frames never truncated.
- Stage 0 (comb. from counters): active = hcnt<H_ACTIVE && vcnt<V_ACTIVE; RE=active; Addr=linear pixel index.
- Addr from incrementing counter (no multiplier): +1 per active pixel, cleared to 0 at frame start; last pixel = H_ACTIVE*V_ACTIVE-1. Width-truncated to ADDR_W.
- Stage 1 (registered): de, hsync, vsync, frame_start registered one clock after counters, aligned with buffer data. RGB_out = de ? {R_in,G_in,B_in} : 0. Total latency counters->pins: 1 clock.
- hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), full lines.
- Reset mid-frame: all outputs to reset values immediately; restart from (0,0) once reset=1 and en=1.

Optional Feature:
SCANOUT_PATTERN_EN. Defined: extra input pat_en (1 bit); when 1, RE forced 0 and RGB_out during de = 8 vertical colour bars (bar = hcnt*8/H_ACTIVE; colours white, yellow, cyan, green, magenta, red, blue, black), pipelined to same 1-clock alignment; pat_en sampled per pixel. Undefined: no pat_en port, buffer data always used.

Decomposition:
- Shared package display_pkg: rgb888 struct typedef, scan state enum (IDLE/RUN/DRAIN), colour-bar constant table.
- One sub-module: scan_timing_gen (hcnt/vcnt, active, sync-region flags, frame_start); top holds FSM, address counter, output pipeline.

Test Plan:
- Params H_ACTIVE=4,V_ACTIVE=3, porches/syncs all 1 (H_TOTAL=7, V_TOTAL=6); en=1 -> frame_start every 42 clocks; Addr 0..11 with RE high 12 clocks per frame; de high 4 clocks per line for lines 0..2.
- Buffer model returns data=addr+0x10 -> RGB_out sequence 0x10..0x1B exactly when de=1; 0 otherwise; hsync low at hcnt 5 (pins 1 clock later).
- en dropped at line 1 -> frame completes (Addr reaches 11), then IDLE: RE=0, hsync=vsync=1, no further frame_start.
- reset pulsed low mid-line 2 -> outputs reset on same edge, no clock needed; after release with en=1 the first frame_start occurs and Addr restarts at 0.
- en low one cycle then high within same frame -> no gap, counters continuous, single frame_start per 42 clocks.
- SCANOUT_PATTERN_EN, pat_en=1, H_ACTIVE=8 -> RE=0, RGB_out per pixel = bar colours 0xFFFFFF, 0xFFFF00, ..., 0x000000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display types: pixel struct, scan states, colour-bar table.
// Used by buf_scanout (optional SCANOUT_PATTERN_EN test pattern).
package display_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } scan_state_t;

  function automatic rgb888_t bar_colour(
    input logic [2:0] idx
  );
    rgb888_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/buf_scanout_if.sv
// Frame-buffer read port: read enable and address out,
// registered RGB data back one cycle later.
interface buf_scanout_if #(
  parameter int ADDR_W = 20
);

  logic              RE;
  logic [ADDR_W-1:0] Addr;
  logic [7:0]        R_in;
  logic [7:0]        G_in;
  logic [7:0]        B_in;

  modport master (
    output RE,
    output Addr,
    input  R_in,
    input  G_in,
    input  B_in
  );

  modport slave (
    input  RE,
    input  Addr,
    output R_in,
    output G_in,
    output B_in
  );

endinterface

// File: rtl/scan_timing_gen.sv
// Raster counters plus combinational active/sync/frame flags.
// SCANOUT_PATTERN_EN adds the colour-bar index output.
module scan_timing_gen #(
  parameter int H_ACTIVE = 100,
  parameter int V_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL + 1),
  localparam int VW = $clog2(V_TOTAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic active,
  output logic hs_zone,
  output logic vs_zone,
  output logic sof,
  output logic eof
`ifdef SCANOUT_PATTERN_EN
  ,
  output logic [2:0] bar
`endif
);

  localparam logic [HW-1:0] H_END =
    HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG =
    HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST =
    HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_END =
    VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG =
    VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST =
    VW'(V_TOTAL - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      if (vcnt == V_LAST)
        vcnt <= '0;
      else
        vcnt <= vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign active = run
    && (hcnt < H_END)
    && (vcnt < V_END);

  assign hs_zone = run
    && (hcnt >= HS_BEG)
    && (hcnt < HS_END);

  // Vertical sync spans whole lines.
  assign vs_zone = run
    && (vcnt >= VS_BEG)
    && (vcnt < VS_END);

  assign sof = run
    && (hcnt == '0)
    && (vcnt == '0);

  assign eof = run
    && (hcnt == H_LAST)
    && (vcnt == V_LAST);

`ifdef SCANOUT_PATTERN_EN
  assign bar = 3'(
    (32'(hcnt) << 3) / H_ACTIVE);
`endif

endmodule

// File: rtl/buf_scanout.sv
// Frame-buffer scan-out: FSM, address counter, output re-timing.
// Define SCANOUT_PATTERN_EN for the pat_en colour-bar generator.
module buf_scanout
  import display_pkg::*;
#(
  parameter int H_ACTIVE = 100,
  parameter int V_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  parameter int ADDR_W   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
`ifdef SCANOUT_PATTERN_EN
  input  logic       pat_en,
`endif
  buf_scanout_if.master fb,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  scan_state_t       state;
  logic              run;
  logic              active;
  logic              hs_zone;
  logic              vs_zone;
  logic              sof;
  logic              eof;
  logic              pat_sel;
  logic [ADDR_W-1:0] addr;
  rgb888_t           pix;

`ifdef SCANOUT_PATTERN_EN
  logic [2:0] bar;
  logic       pat_q;
  rgb888_t    pat_rgb;
  assign pat_sel = pat_en;
`else
  assign pat_sel = 1'b0;
`endif

  assign run = (state != IDLE);

  scan_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (clk),
    .rst_n   (reset),
    .run     (run),
    .active  (active),
    .hs_zone (hs_zone),
    .vs_zone (vs_zone),
    .sof     (sof),
    .eof     (eof)
`ifdef SCANOUT_PATTERN_EN
    ,
    .bar     (bar)
`endif
  );

  // Frames always complete; en only matters at the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (en) state <= RUN;
        RUN:
          if (!en) state <= eof ? IDLE : DRAIN;
        DRAIN:
          if (en)       state <= RUN;
          else if (eof) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      addr <= '0;
    else if (!run || eof)
      addr <= '0;
    else if (active)
      addr <= addr + ADDR_W'(1);
  end

  assign fb.RE   = active && !pat_sel;
  assign fb.Addr = addr;

  // Pins register one clock after the counters so they
  // line up with the buffer's registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      de          <= active;
      hsync       <= !hs_zone;
      vsync       <= !vs_zone;
      frame_start <= sof;
    end
  end

`ifdef SCANOUT_PATTERN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= 1'b0;
      pat_rgb <= '0;
    end else begin
      pat_q   <= pat_sel;
      pat_rgb <= bar_colour(bar);
    end
  end
`endif

  always_comb begin
    pix = '0;
    if (de)
      pix = {fb.R_in, fb.G_in, fb.B_in};
`ifdef SCANOUT_PATTERN_EN
    if (de && pat_q)
      pix = pat_rgb;
`endif
  end

  assign R_out = pix.r;
  assign G_out = pix.g;
  assign B_out = pix.b;

endmodule

// File: tb/tb_buf_scanout.sv
// Directed bench for buf_scanout on a 4x3 raster (7x6 total).
// Optional second instance covers SCANOUT_PATTERN_EN.
module tb_buf_scanout;

  localparam int HT = 7;
  localparam int VT = 6;
  localparam int HA = 4;
  localparam int VA = 3;

  logic clk = 1'b0;
  logic reset;
  logic en;
  always #5 clk = ~clk;

  buf_scanout_if #(.ADDR_W(20)) fb();

  logic [7:0] R_out, G_out, B_out;
  logic       hsync, vsync, de, frame_start;
  logic [23:0] rgb;
  assign rgb = {R_out, G_out, B_out};

`ifdef SCANOUT_PATTERN_EN
  logic pat_en = 1'b0;
`endif

  buf_scanout #(
    .H_ACTIVE (4), .V_ACTIVE (3),
    .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_FP (1), .V_SYNC (1), .V_BP (1),
    .ADDR_W (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
`ifdef SCANOUT_PATTERN_EN
    .pat_en      (pat_en),
`endif
    .fb          (fb),
    .R_out       (R_out),
    .G_out       (G_out),
    .B_out       (B_out),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  // Registered buffer: data = addr + 0x10, junk when not read.
  always @(posedge clk) begin
    if (fb.RE)
      {fb.R_in, fb.G_in, fb.B_in} <=
        {16'h0, fb.Addr[7:0] + 8'h10};
    else
      {fb.R_in, fb.G_in, fb.B_in} <= 24'hA5A5A5;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_re"},    fb.RE, 0);
    chk({tag, "_addr"},  fb.Addr, 0);
    chk({tag, "_de"},    de, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_rgb"},   rgb, 0);
    chk({tag, "_fs"},    frame_start, 0);
  endtask

  // k = clocks since the first running cycle (counters at 0,0).
  task automatic chk_cycle(input int k);
    int h, v, hp, vp;
    bit act, actp;
    h   = k % HT;
    v   = (k / HT) % VT;
    act = (h < HA) && (v < VA);
    chk($sformatf("re@%0d", k), fb.RE, act);
    if (act)
      chk($sformatf("addr@%0d", k),
          fb.Addr, v * HA + h);
    if (k == 0) begin
      chk("de@0", de, 0);
      chk("hsync@0", hsync, 1);
      chk("vsync@0", vsync, 1);
      chk("fs@0", frame_start, 0);
      chk("rgb@0", rgb, 0);
    end else begin
      hp   = (k - 1) % HT;
      vp   = ((k - 1) / HT) % VT;
      actp = (hp < HA) && (vp < VA);
      chk($sformatf("de@%0d", k), de, actp);
      chk($sformatf("hsync@%0d", k),
          hsync, hp != 5);
      chk($sformatf("vsync@%0d", k),
          vsync, vp != 4);
      chk($sformatf("fs@%0d", k), frame_start,
          ((k - 1) % 42) == 0);
      chk($sformatf("rgb@%0d", k), rgb,
          actp ? (vp * HA + hp + 16) : 0);
    end
  endtask

`ifdef SCANOUT_PATTERN_EN
  buf_scanout_if #(.ADDR_W(20)) fb2();
  logic [7:0] R2, G2, B2;
  logic       hs2, vs2, de2, fs2;
  logic       en2 = 1'b0;
  assign fb2.R_in = 8'h5A;
  assign fb2.G_in = 8'h5A;
  assign fb2.B_in = 8'h5A;

  buf_scanout #(
    .H_ACTIVE (8), .V_ACTIVE (3),
    .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_FP (1), .V_SYNC (1), .V_BP (1),
    .ADDR_W (20)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .en          (en2),
    .pat_en      (1'b1),
    .fb          (fb2),
    .R_out       (R2),
    .G_out       (G2),
    .B_out       (B2),
    .hsync       (hs2),
    .vsync       (vs2),
    .de          (de2),
    .frame_start (fs2)
  );
`endif

  int re_cnt;
  int fs_cnt;
  int last_addr;

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    #3 reset = 1'b0;
    #9;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_re", fb.RE, 0);
    chk("idle_fs", frame_start, 0);

    // Free-running, then en dropped on line 1 of frame 3.
    en = 1'b1;
    re_cnt = 0;
    last_addr = -1;
    for (int k = 0; k < 126; k++) begin
      @(negedge clk);
      chk_cycle(k);
      if (k < 42 && fb.RE) re_cnt++;
      if (k >= 84 && fb.RE)
        last_addr = int'(fb.Addr);
      if (k == 91) en = 1'b0;
    end
    chk("re_per_frame", re_cnt, 12);
    chk("drain_last_addr", last_addr, 11);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("drained_re", fb.RE, 0);
      chk("drained_fs", frame_start, 0);
      chk("drained_hsync", hsync, 1);
      chk("drained_vsync", vsync, 1);
      chk("drained_de", de, 0);
    end

    // One-cycle en glitch, then reset mid line 2.
    en = 1'b1;
    fs_cnt = 0;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      chk_cycle(k);
      if (k >= 1 && k <= 84 && frame_start)
        fs_cnt++;
      if (k == 10) en = 1'b0;
      if (k == 11) en = 1'b1;
    end
    chk("glitch_fs_count", fs_cnt, 2);
    #2 reset = 1'b0;
    #1 chk_reset("async");

    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      chk_cycle(k);
    end
    en = 1'b0;
    repeat (45) @(negedge clk);
    chk("final_idle_re", fb.RE, 0);
    chk("final_idle_hsync", hsync, 1);

`ifdef SCANOUT_PATTERN_EN
    begin
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00,
               24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000,
               24'h0000FF, 24'h000000};
      en2 = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk($sformatf("pat_re@%0d", k), fb2.RE, 0);
        if (k >= 1 && k <= 8) begin
          chk($sformatf("pat_de@%0d", k), de2, 1);
          chk($sformatf("pat_rgb@%0d", k),
              {R2, G2, B2}, bars[k-1]);
        end
      end
      en2 = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
